seq_mul_unit: RTL
=================

Name: seq_mul_unit

Overview:
- Iterative shift-add multiplier for the execute stage.
- Produces the 32-bit multiply result that feeds a spare input of the ALU result select multiplexer.
- Supports the four RV32M multiply flavours.
- Multi-cycle: raises busy so the pipeline controller stalls issue until done.

Parameters:
- DATA_WIDTH, 32, operand and result width (even, >= 4).
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset.
- start  input  1  request; sampled only while idle.
- mul_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- op_a  input  DATA_WIDTH  multiplicand (rs1).
- op_b  input  DATA_WIDTH  multiplier (rs2).
- busy  output  1  high from the cycle after acceptance through the done cycle.
- done  output  1  one-cycle pulse; result valid.
- result  output  DATA_WIDTH  selected product half; held until the next accepted start.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n=0, immediate, independent of clk):
  - state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulator=0.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start=1 at an edge: latch mul_op.
  - Latch magnitudes of op_a/op_b:
    - op_a is signed for MULH/MULHSU.
    - op_b is signed for MULH only.
    - MUL treats both operands as unsigned (low half is sign-independent).
  - Latch neg_flag = sign_a XOR sign_b, using only the operands treated as signed.
  - Clear the 2*DATA_WIDTH accumulator; counter=0; go to CALC.
- CALC: one iteration per cycle.
  - If the multiplier LSB=1, add the multiplicand magnitude into the upper half (DATA_WIDTH+1-bit add, carry kept).
  - Shift the {carry, accumulator} pair right by 1; counter++.
  - After exactly DATA_WIDTH iterations, go to FINISH.
- FINISH:
  - Product = neg_flag ? two's-complement of the 2*DATA_WIDTH accumulator : accumulator.
  - result <= low half for MUL, high half otherwise.
  - done=1 for this single cycle; return to IDLE.
- Latency:
  - start sampled at edge k: busy=1 after edge k, done=1 after edge k+DATA_WIDTH+1 (33 cycles at default).
  - Next start accepted at edge k+DATA_WIDTH+2 at the earliest.
- Boundary and corner cases:
  - start while busy: ignored; no queuing; operands and op changes are ignored.
  - Most-negative operand (0x80000000): magnitude 2^31 fits in DATA_WIDTH unsigned bits; no overflow.
  - Zero product with neg_flag=1: negation yields 0; no -0 artefact.
  - Reset mid-CALC: abort immediately to the reset state; result is cleared to 0.
- result and done are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - mul_op encodings (MUL_LO, MULH_SS, MULH_SU, MULH_UU).
  - State encodings (IDLE, CALC, FINISH).
  - Default DATA_WIDTH.
- One natural sub-module: twos_negate, a parameterised 2*DATA_WIDTH conditional negator (in, en, out). It is reused for operand magnitude conversion at DATA_WIDTH.

Test Plan:
- MUL 7 x 6 -> done exactly 33 cycles after start; result=0x0000002A; busy low the cycle after done.
- MULH 0x80000000 x 0x80000000 -> result=0x40000000; MUL with the same operands -> result=0x00000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
- Signed sign handling:
  - MULH 0xFFFFFFFF x 0x00000001 -> 0xFFFFFFFF.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULH 0x00000000 x 0xFFFFFFFF -> 0x00000000.
- Busy start and operand changes:
  - Start MUL 3 x 5; pulse start with 9 x 9 at cycle 10 and change operands mid-CALC -> single done, result=0x0000000F.
  - A second done must never appear.
- Reset mid-operation and back-to-back starts:
  - Assert rst_n=0 asynchronously at cycle 15 of a MULHU -> busy, done and result drop to 0 immediately, without waiting for a clock edge.
  - After release, a fresh MUL 2 x 2 -> 4.
  - Back-to-back: start re-asserted in the cycle after done is accepted.

Source files
------------

// File: rtl/seq_mul_unit_pkg.sv
// Shared encodings for the iterative shift-add multiplier.
package seq_mul_unit_pkg;

   localparam int unsigned DefDataWidth = 32;

   // RV32M multiply flavours as carried on mul_op
   localparam logic [1:0] MUL_LO  = 2'b00;
   localparam logic [1:0] MULH_SS = 2'b01;
   localparam logic [1:0] MULH_SU = 2'b10;
   localparam logic [1:0] MULH_UU = 2'b11;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StCalc   = 2'b01,
      StFinish = 2'b10
   } mul_state_e;

endpackage

// File: rtl/seq_mul_unit_twos_negate.sv
// Conditional two's-complement negator; passes din through when en is low.
module twos_negate #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      dout = din;
      if (en) dout = (~din) + WIDTH'(1);
   end

endmodule

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier: one partial product per cycle on operand magnitudes,
// sign restored on the full double-width product in the finish cycle.
module seq_mul_unit
   import seq_mul_unit_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            mul_op,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int unsigned W = DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LastIter = CNT_WIDTH'(DATA_WIDTH - 1);

   mul_state_e         state_q;
   logic [1:0]         op_q;
   logic               neg_q;
   logic [W-1:0]       mcand_q;
   logic [W-1:0]       mplier_q;
   logic [2*W-1:0]     acc_q;
   logic [CNT_WIDTH-1:0] cnt_q;

   logic               a_neg, b_neg;
   logic [W-1:0]       mag_a, mag_b;
   logic [W-1:0]       addend;
   logic [W:0]         sum;
   logic [2*W-1:0]     product;

   // Only operands interpreted as signed contribute a sign
   assign a_neg = ((mul_op == MULH_SS) || (mul_op == MULH_SU)) && op_a[W-1];
   assign b_neg = (mul_op == MULH_SS) && op_b[W-1];

   twos_negate #(.WIDTH(W)) u_mag_a (
      .din  (op_a),
      .en   (a_neg),
      .dout (mag_a)
   );

   twos_negate #(.WIDTH(W)) u_mag_b (
      .din  (op_b),
      .en   (b_neg),
      .dout (mag_b)
   );

   twos_negate #(.WIDTH(2 * W)) u_prod (
      .din  (acc_q),
      .en   (neg_q),
      .dout (product)
   );

   assign addend = mplier_q[0] ? mcand_q : '0;
   assign sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         op_q     <= MUL_LO;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  op_q     <= mul_op;
                  mcand_q  <= mag_a;
                  mplier_q <= mag_b;
                  neg_q    <= a_neg ^ b_neg;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  busy     <= 1'b1;
                  state_q  <= StCalc;
               end else begin
                  busy <= 1'b0;
               end
            end
            StCalc: begin
               // Carry of the add becomes the new MSB; low bits settle into the lower half
               acc_q    <= {sum, acc_q[W-1:1]};
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_WIDTH'(1);
               if (cnt_q == LastIter) state_q <= StFinish;
            end
            StFinish: begin
               result  <= (op_q == MUL_LO) ? product[W-1:0] : product[2*W-1:W];
               done    <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
